time_manager: RTL and testbench

Central time-advance controller for the event-driven emulator. It gathers the `time_clock` value of every emulated clock generator and reduces them to their minimum through a registered tree. It then broadcasts that minimum as `time_next` with a one-cycle `step_valid` strobe, so each generator whose time matches fires its gated clock. It also provides run/single-step control, a stop-time breakpoint, and a step counter for the host interface.

---
 rtl/time_manager.sv | 129 ++++++++++++
 tb/tb_time_manager.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_manager.sv
// Time-advance controller: reduces all generator times to their minimum and
// issues it as a step strobe, with run/single-step control and a stop-time breakpoint.
package time_package;
  typedef logic [31:0] TIME_FORMAT;
endpackage

// state  | meaning
// IDLE   | waiting for run or single_step
// SAMPLE | capture every generator time
// REDUCE | one registered pairwise-min level per cycle
// ISSUE  | strobe time_next and count the step
// HALT   | minimum passed stop_time, waiting for clear_halt
module time_manager
  import time_package::*;
#(
  parameter int N_CLK     = 4,
  parameter int STEP_BITS = 32
) (
  input  logic                                clk_sys,
  input  logic                                rst_n,
  input  logic                                run,
  input  logic                                single_step,
  input  logic                                clear_halt,
  input  TIME_FORMAT                          stop_time,
  input  logic [N_CLK*$bits(TIME_FORMAT)-1:0] time_clocks,
  output TIME_FORMAT                          time_next,
  output logic                                step_valid,
  output logic [STEP_BITS-1:0]                step_count,
  output logic                                busy,
  output logic                                halted
);

  localparam int TW = $bits(TIME_FORMAT);
  localparam int LVLS = (N_CLK <= 1) ? 0 : $clog2(N_CLK);
  localparam logic [2:0] LVL_LOAD = 3'((LVLS > 0) ? LVLS - 1 : 0);

  typedef enum logic [2:0] {IDLE, SAMPLE, REDUCE, ISSUE, HALT} state_t;

  state_t     state;
  logic [2:0] lvl_cnt;
  TIME_FORMAT time_in  [N_CLK];
  TIME_FORMAT red      [N_CLK];
  TIME_FORMAT red_next [N_CLK];
  TIME_FORMAT min_val;
  logic       limit_now;

  // The tree is folded in place: slot i takes min(2i, 2i+1) each level. Slots
  // past the live width keep older partial minima, which never undercut the
  // true minimum, so slot 0 is exact after LVLS levels.
  for (genvar i = 0; i < N_CLK; i++) begin : g_red
    assign time_in[i] = time_clocks[i*TW +: TW];
    if (2*i + 1 < N_CLK) begin : g_pair
      assign red_next[i] = (red[2*i+1] < red[2*i]) ? red[2*i+1] : red[2*i];
    end else if (2*i < N_CLK) begin : g_pass
      assign red_next[i] = red[2*i];
    end else begin : g_hold
      assign red_next[i] = red[i];
    end
  end

  assign min_val   = (LVLS == 0) ? time_in[0] : red_next[0];
  assign limit_now = ((state == SAMPLE) && (LVLS == 0)) ||
                     ((state == REDUCE) && (lvl_cnt == 3'd0));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lvl_cnt    <= '0;
      time_next  <= '0;
      step_valid <= 1'b0;
      step_count <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      for (int i = 0; i < N_CLK; i++) red[i] <= '0;
    end else begin
      step_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run || single_step) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          for (int i = 0; i < N_CLK; i++) red[i] <= time_in[i];
          state   <= REDUCE;
          lvl_cnt <= LVL_LOAD;
        end
        REDUCE: begin
          for (int i = 0; i < N_CLK; i++) red[i] <= red_next[i];
          if (lvl_cnt != 3'd0) lvl_cnt <= lvl_cnt - 3'd1;
        end
        ISSUE: begin
          if (run) begin
            state <= SAMPLE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HALT: begin
          if (clear_halt) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Limit check overrides the next state chosen above.
      if (limit_now) begin
        if (min_val > stop_time) begin
          state  <= HALT;
          halted <= 1'b1;
          busy   <= 1'b0;
        end else begin
          state      <= ISSUE;
          time_next  <= min_val;
          step_valid <= 1'b1;
          if (step_count != '1) step_count <= step_count + STEP_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_manager.sv
// Randomized self-checking bench for time_manager: a 4-generator instance and a
// single-generator 4-bit-counter instance, both checked against a min-based model.
module tb_time_manager;
  import time_package::*;

  localparam int N = 4;
  localparam int L = 2;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic             rst_n;
  logic             run, single_step, clear_halt;
  TIME_FORMAT       stop_time;
  logic [N*32-1:0]  time_clocks;
  TIME_FORMAT       time_next;
  logic             step_valid;
  logic [31:0]      step_count;
  logic             busy, halted;

  logic             run1, ss1, ch1;
  TIME_FORMAT       stop1, tc1, tn1;
  logic             sv1, busy1, halted1;
  logic [3:0]       cnt1;

  time_manager #(.N_CLK(N), .STEP_BITS(32)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .run(run), .single_step(single_step),
    .clear_halt(clear_halt), .stop_time(stop_time), .time_clocks(time_clocks),
    .time_next(time_next), .step_valid(step_valid), .step_count(step_count),
    .busy(busy), .halted(halted));

  time_manager #(.N_CLK(1), .STEP_BITS(4)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .run(run1), .single_step(ss1),
    .clear_halt(ch1), .stop_time(stop1), .time_clocks(tc1),
    .time_next(tn1), .step_valid(sv1), .step_count(cnt1),
    .busy(busy1), .halted(halted1));

  int n_checks = 0;
  int n_fail   = 0;

  TIME_FORMAT gens [4];
  TIME_FORMAT incs [4];
  TIME_FORMAT seq  [9];
  longint     exp_count;
  TIME_FORMAT exp_tn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_times(input TIME_FORMAT t0, t1, t2, t3);
    gens[0] = t0; gens[1] = t1; gens[2] = t2; gens[3] = t3;
    time_clocks = {t3, t2, t1, t0};
  endtask

  function automatic TIME_FORMAT model_min();
    TIME_FORMAT m = gens[0];
    for (int i = 1; i < 4; i++) if (gens[i] < m) m = gens[i];
    return m;
  endfunction

  // Pulse single_step before edge E; sample #1 after E (k=0) and 11 more edges.
  task automatic step_and_watch(output int sv_n, output int sv_at, output int busy_n,
                                output TIME_FORMAT tn_seen, output int halt_at);
    sv_n = 0; sv_at = -1; busy_n = 0; tn_seen = '0; halt_at = -1;
    @(negedge clk_sys); single_step = 1'b1;
    @(posedge clk_sys); #1; single_step = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy) busy_n++;
      if (halted && halt_at < 0) halt_at = k;
      if (step_valid) begin
        if (sv_n == 0) begin sv_at = k; tn_seen = time_next; end
        sv_n++;
      end
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic run_step_case(input string tag, input TIME_FORMAT stop);
    int sv_n, sv_at, busy_n, halt_at;
    TIME_FORMAT tn_seen, mn;
    stop_time = stop;
    mn = model_min();
    step_and_watch(sv_n, sv_at, busy_n, tn_seen, halt_at);
    if (mn > stop) begin
      check({tag, "_halt_at"}, 64'(halt_at), 64'(L + 1));
      check({tag, "_no_strobe"}, 64'(sv_n), 64'd0);
      check({tag, "_tn_held"}, 64'(time_next), 64'(exp_tn));
      check({tag, "_cnt_held"}, 64'(step_count), 64'(exp_count));
      check({tag, "_halted"}, 64'(halted), 64'd1);
      leave_halt(tag);
    end else begin
      exp_count++;
      exp_tn = mn;
      check({tag, "_strobes"}, 64'(sv_n), 64'd1);
      // strobe cycle E+2+L begins at edge E+L+1
      check({tag, "_latency"}, 64'(sv_at), 64'(L + 1));
      check({tag, "_tn"}, 64'(tn_seen), 64'(mn));
      check({tag, "_cnt"}, 64'(step_count), 64'(exp_count));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(L + 2));
      check({tag, "_idle"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic leave_halt(input string tag);
    int sv = 0;
    @(negedge clk_sys); run = 1'b1; single_step = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_sys); #1; single_step = 1'b0;
      if (step_valid) sv++;
    end
    check({tag, "_halt_ignores_run"}, 64'(halted), 64'd1);
    check({tag, "_halt_no_step"}, 64'(sv), 64'd0);
    run = 1'b0;
    @(negedge clk_sys); clear_halt = 1'b1;
    @(posedge clk_sys); #1; clear_halt = 1'b0;
    check({tag, "_clear_halted"}, 64'(halted), 64'd0);
    check({tag, "_clear_busy"}, 64'(busy), 64'd0);
    sv = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_sys); #1;
      if (step_valid) sv++;
    end
    check({tag, "_after_clear_no_step"}, 64'(sv), 64'd0);
  endtask

  initial begin
    int nstrobe, cyc, last_at, sv_n;
    TIME_FORMAT mn;
    rst_n = 1'b0; run = 1'b0; single_step = 1'b0; clear_halt = 1'b0;
    stop_time = '0; time_clocks = '0;
    run1 = 1'b0; ss1 = 1'b0; ch1 = 1'b0; stop1 = '1; tc1 = '0;
    seq = '{0, 3, 4, 5, 6, 7, 8, 9, 10};
    incs = '{5, 3, 7, 4};
    exp_count = 0; exp_tn = '0;
    set_times(0, 0, 0, 0);

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_valid", 64'(step_valid), 64'd0);
    check("rst_tn", 64'(time_next), 64'd0);
    check("rst_cnt", 64'(step_count), 64'd0);
    check("rst_cnt1", 64'(cnt1), 64'd0);
    @(negedge clk_sys); rst_n = 1'b1;

    // directed: single step, breakpoint, equality
    set_times(10, 3, 7, 3);
    run_step_case("single", 100);
    set_times(6, 9, 8, 7);
    run_step_case("brk", 5);
    set_times(5, 9, 8, 7);
    run_step_case("equal", 5);

    // randomized single steps
    for (int it = 0; it < 10; it++) begin
      set_times($urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 63), $urandom_range(0, 63));
      run_step_case("rand", $urandom_range(0, 63));
    end

    // continuous run with four generators
    set_times(0, 0, 0, 0);
    stop_time = '1;
    @(negedge clk_sys); run = 1'b1;
    nstrobe = 0; cyc = 0; last_at = -1;
    while (nstrobe < 20 && cyc < 200) begin
      @(posedge clk_sys); #1; cyc++;
      if (step_valid) begin
        mn = model_min();
        exp_count++;
        check("run_tn", 64'(time_next), 64'(mn));
        if (nstrobe < 9) check("run_seq", 64'(time_next), 64'(seq[nstrobe]));
        if (last_at >= 0) check("run_period", 64'(cyc - last_at), 64'(L + 2));
        check("run_cnt", 64'(step_count), 64'(exp_count));
        last_at = cyc; nstrobe++;
        for (int g = 0; g < 4; g++) if (gens[g] == mn) gens[g] += incs[g];
        time_clocks = {gens[3], gens[2], gens[1], gens[0]};
      end
    end
    check("run_strobes", 64'(nstrobe), 64'd20);

    // drop run mid-step: that step still issues, then idle
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1; run = 1'b0;
    mn = model_min();
    sv_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (step_valid) begin
        sv_n++;
        check("stop_mid_tn", 64'(time_next), 64'(mn));
      end
      @(posedge clk_sys); #1;
    end
    exp_count++;
    check("stop_mid_strobes", 64'(sv_n), 64'd1);
    check("stop_mid_idle", 64'(busy), 64'd0);
    check("stop_mid_cnt", 64'(step_count), 64'(exp_count));

    // reset during REDUCE
    set_times(40, 41, 42, 43);
    stop_time = 100;
    @(negedge clk_sys); single_step = 1'b1;
    @(posedge clk_sys); #1; single_step = 1'b0;
    @(posedge clk_sys); #2; rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_cnt", 64'(step_count), 64'd0);
    check("mid_rst_tn", 64'(time_next), 64'd0);
    check("mid_rst_valid", 64'(step_valid), 64'd0);
    check("mid_rst_halted", 64'(halted), 64'd0);
    exp_count = 0; exp_tn = '0;
    @(negedge clk_sys); rst_n = 1'b1;
    sv_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_sys); #1;
      if (step_valid) sv_n++;
    end
    check("post_rst_no_strobe", 64'(sv_n), 64'd0);

    // second single_step during a busy step is dropped
    set_times(9, 8, 20, 30);
    @(negedge clk_sys); single_step = 1'b1;
    @(posedge clk_sys); #1; single_step = 1'b0;
    @(negedge clk_sys); single_step = 1'b1;
    @(posedge clk_sys); #1; single_step = 1'b0;
    sv_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (step_valid) begin
        sv_n++;
        check("busy_drop_tn", 64'(time_next), 64'd8);
      end
      @(posedge clk_sys); #1;
    end
    check("busy_drop_strobes", 64'(sv_n), 64'd1);
    check("busy_drop_cnt", 64'(step_count), 64'd1);

    // saturation on the single-generator, 4-bit-counter instance
    tc1 = TIME_FORMAT'($urandom);
    mn = tc1;
    @(negedge clk_sys); run1 = 1'b1;
    nstrobe = 0; cyc = 0; last_at = -1;
    while (nstrobe < 20 && cyc < 200) begin
      @(posedge clk_sys); #1; cyc++;
      if (sv1) begin
        nstrobe++;
        check("sat_tn", 64'(tn1), 64'(mn));
        check("sat_cnt", 64'(cnt1), 64'((nstrobe > 15) ? 15 : nstrobe));
        if (last_at >= 0) check("sat_period", 64'(cyc - last_at), 64'd2);
        last_at = cyc;
        tc1 = TIME_FORMAT'($urandom);
        mn = tc1;
      end
    end
    check("sat_strobes", 64'(nstrobe), 64'd20);
    run1 = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    check("sat_final", 64'(cnt1), 64'd15);
    check("sat_idle", 64'(busy1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
